// File: rtl/mwr_tlp_assembler_if.sv
// TLP beat stream from the MWr assembler to the data link layer.
// A beat transfers on a rising edge where tlp_valid && tlp_ready; while tlp_valid is high and tlp_ready low the source holds every field stable.
interface mwr_tlp_assembler_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  tlp_valid;
    logic [DATA_WIDTH-1:0] tlp_data;
    logic                  tlp_sop;
    logic                  tlp_eop;
    logic                  tlp_len_err;
    logic                  tlp_ready;

    modport master (
        output tlp_valid,
        output tlp_data,
        output tlp_sop,
        output tlp_eop,
        output tlp_len_err,
        input  tlp_ready
    );

    modport slave (
        input  tlp_valid,
        input  tlp_data,
        input  tlp_sop,
        input  tlp_eop,
        input  tlp_len_err,
        output tlp_ready
    );
endinterface

// File: rtl/mwr_tlp_assembler.sv
// Builds MWr TLPs: one header beat from the header FIFO, then payload beats up to the stored wlast.
// Flags a payload beat count that disagrees with the header Length on the eop beat.
module mwr_tlp_assembler #(
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_fifo_empty,
    input  logic [HDR_WIDTH-1:0]  hdr_fifo_rdata,
    output logic                  hdr_fifo_rden,
    input  logic                  payload_fifo_empty,
    input  logic [DATA_WIDTH-1:0] payload_fifo_rdata,
    input  logic                  payload_fifo_rlast,
    output logic                  payload_fifo_rden,
    mwr_tlp_assembler_if.master   tlp,
    output logic                  dbg_state
);
    localparam int DW_PER_BEAT = DATA_WIDTH / 32;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t      state;
    logic [10:0] beat_cnt;
    logic [10:0] exp_beats;
    logic [10:0] cnt_next;
    logic [10:0] len_dw;
    logic [15:0] len_round;
    logic [10:0] exp_calc;
    logic        slot_free;

    assign dbg_state = state;
    assign slot_free = !tlp.tlp_valid || tlp.tlp_ready;
    assign cnt_next  = beat_cnt + 11'd1;

    // Pops depend only on state, FIFO emptiness and the output slot, never on rdata.
    assign hdr_fifo_rden     = (state == IDLE) && !hdr_fifo_empty && slot_free;
    assign payload_fifo_rden = (state == DATA) && !payload_fifo_empty && slot_free;

    // Length of 0 encodes 1024 DW; round the DW count up to whole beats.
    always_comb begin
        len_dw    = (hdr_fifo_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_fifo_rdata[9:0]};
        len_round = {5'd0, len_dw} + 16'(DW_PER_BEAT - 1);
        exp_calc  = 11'(len_round / 16'(DW_PER_BEAT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            exp_beats       <= '0;
            tlp.tlp_valid   <= 1'b0;
            tlp.tlp_data    <= '0;
            tlp.tlp_sop     <= 1'b0;
            tlp.tlp_eop     <= 1'b0;
            tlp.tlp_len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_fifo_rden) begin
                        tlp.tlp_valid   <= 1'b1;
                        tlp.tlp_data    <= DATA_WIDTH'(hdr_fifo_rdata);
                        tlp.tlp_sop     <= 1'b1;
                        tlp.tlp_eop     <= 1'b0;
                        tlp.tlp_len_err <= 1'b0;
                        exp_beats       <= exp_calc;
                        beat_cnt        <= '0;
                        state           <= DATA;
                    end else if (slot_free) begin
                        tlp.tlp_valid <= 1'b0;
                    end
                end
                DATA: begin
                    if (payload_fifo_rden) begin
                        tlp.tlp_valid <= 1'b1;
                        tlp.tlp_data  <= payload_fifo_rdata;
                        tlp.tlp_sop   <= 1'b0;
                        tlp.tlp_eop   <= payload_fifo_rlast;
                        beat_cnt      <= cnt_next;
                        // The stored wlast ends the TLP regardless of the header Length.
                        if (payload_fifo_rlast) begin
                            tlp.tlp_len_err <= (cnt_next != exp_beats);
                            state           <= IDLE;
                        end else begin
                            tlp.tlp_len_err <= 1'b0;
                        end
                    end else if (slot_free) begin
                        tlp.tlp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mwr_tlp_assembler.sv
// Directed bench for mwr_tlp_assembler: FWFT FIFO models feed the DUT, a scoreboard checks every accepted beat.
module tb_mwr_tlp_assembler;
    localparam int DW = 256;
    localparam int HW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hdr_fifo_empty;
    logic [HW-1:0] hdr_fifo_rdata;
    logic          hdr_fifo_rden;
    logic          payload_fifo_empty;
    logic [DW-1:0] payload_fifo_rdata;
    logic          payload_fifo_rlast;
    logic          payload_fifo_rden;
    logic          dbg_state;

    mwr_tlp_assembler_if #(.DATA_WIDTH(DW)) tlp_bus ();

    mwr_tlp_assembler #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .hdr_fifo_empty     (hdr_fifo_empty),
        .hdr_fifo_rdata     (hdr_fifo_rdata),
        .hdr_fifo_rden      (hdr_fifo_rden),
        .payload_fifo_empty (payload_fifo_empty),
        .payload_fifo_rdata (payload_fifo_rdata),
        .payload_fifo_rlast (payload_fifo_rlast),
        .payload_fifo_rden  (payload_fifo_rden),
        .tlp                (tlp_bus.master),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    logic [HW-1:0]   hdr_q[$];
    logic [DW:0]     pay_q[$];
    logic [DW:0]     pay_hold[$];
    logic [DW+2:0]   exp_q[$];
    int              acc_cyc[$];
    int              cyc = 0;
    int              hdr_pops = 0;
    int              pay_pops = 0;
    int              n_tests = 0;
    int              n_fail = 0;
    logic            hdr_pend = 1'b0;
    logic            pay_pend = 1'b0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        hdr_fifo_empty = (hdr_q.size() == 0);
        hdr_fifo_rdata = '0;
        if (hdr_q.size() != 0) hdr_fifo_rdata = hdr_q[0];
        payload_fifo_empty = (pay_q.size() == 0);
        payload_fifo_rdata = '0;
        payload_fifo_rlast = 1'b0;
        if (pay_q.size() != 0) begin
            payload_fifo_rdata = pay_q[0][DW-1:0];
            payload_fifo_rlast = pay_q[0][DW];
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Queue one TLP: header plus nbeats payload beats, of which only n_now are visible at once.
    task automatic push_tlp(input logic [9:0] len, input int nbeats, input int n_now);
        logic [HW-1:0] hdr;
        logic [DW-1:0] hd;
        logic [DW-1:0] d;
        logic          last;
        logic          err;
        int            l_dw;
        int            expb;
        hdr = {$urandom, $urandom, $urandom, $urandom};
        hdr[9:0] = len;
        hdr_q.push_back(hdr);
        l_dw = (len == 10'd0) ? 1024 : int'(len);
        expb = (l_dw * 32 + DW - 1) / DW;
        err  = (nbeats != expb);
        hd = '0;
        hd[HW-1:0] = hdr;
        exp_q.push_back({1'b1, 1'b0, 1'b0, hd});
        for (int i = 0; i < nbeats; i++) begin
            d = rand_data();
            last = (i == nbeats - 1);
            if (i < n_now) pay_q.push_back({last, d});
            else           pay_hold.push_back({last, d});
            exp_q.push_back({1'b0, last, last && err, d});
        end
        refresh();
    endtask

    task automatic release_payload();
        while (pay_hold.size() != 0) pay_q.push_back(pay_hold.pop_front());
        refresh();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0 beats outstanding", exp_q.size());
        end
    endtask

    // FIFO model: pops decided at the rising edge take effect at the following falling edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        hdr_pend <= rst_n && hdr_fifo_rden;
        pay_pend <= rst_n && payload_fifo_rden;
        if (rst_n && hdr_fifo_rden)     hdr_pops <= hdr_pops + 1;
        if (rst_n && payload_fifo_rden) pay_pops <= pay_pops + 1;
    end

    always @(negedge clk) begin
        if (hdr_pend && hdr_q.size() != 0) void'(hdr_q.pop_front());
        if (pay_pend && pay_q.size() != 0) void'(pay_q.pop_front());
        refresh();
    end

    logic [DW+2:0] cur_beat;
    logic [DW+2:0] held_beat;
    logic [DW+2:0] exp_beat;
    logic          hold_pend = 1'b0;

    always @(negedge clk) begin
        cur_beat = {tlp_bus.tlp_sop, tlp_bus.tlp_eop, tlp_bus.tlp_len_err, tlp_bus.tlp_data};
        if (rst_n) begin
            if (hold_pend) check("hold_stable", cur_beat, held_beat);
            if (tlp_bus.tlp_valid && tlp_bus.tlp_ready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_beat observed=%h expected=no beat", cur_beat);
                end
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("beat", cur_beat, exp_beat);
                end
                acc_cyc.push_back(cyc);
            end
            hold_pend = tlp_bus.tlp_valid && !tlp_bus.tlp_ready;
            held_beat = cur_beat;
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, p0, h1, p1, n;
        logic [HW-1:0] hdr;
        tlp_bus.tlp_ready = 1'b1;
        refresh();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tlp_bus.tlp_valid, 1'b0);
        check("rst_sop", tlp_bus.tlp_sop, 1'b0);
        check("rst_eop", tlp_bus.tlp_eop, 1'b0);
        check("rst_len_err", tlp_bus.tlp_len_err, 1'b0);
        check("rst_data", tlp_bus.tlp_data, '0);
        check("rst_state", dbg_state, 1'b0);
        check("rst_hdr_rden", hdr_fifo_rden, 1'b0);
        rst_n = 1'b1;

        // Single TLP, Length=16, two beats, full throughput
        @(posedge clk); #1;
        acc_cyc.delete(); h0 = hdr_pops; p0 = pay_pops;
        push_tlp(10'd16, 2, 2);
        wait_drain(50);
        check("t1_nbeats", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) check("t1_span", acc_cyc[2] - acc_cyc[0], 2);
        check("t1_hdr_pops", hdr_pops - h0, 1);
        check("t1_pay_pops", pay_pops - p0, 2);

        // Backpressure for 4 cycles while beat 2 is on the output
        acc_cyc.delete(); h0 = hdr_pops; p0 = pay_pops;
        push_tlp(10'd16, 2, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tlp_bus.tlp_ready = 1'b0;
        h1 = hdr_pops; p1 = pay_pops;
        repeat (4) @(posedge clk);
        #1;
        check("t2_valid_held", tlp_bus.tlp_valid, 1'b1);
        check("t2_no_pay_pop", pay_pops, p1);
        check("t2_no_hdr_pop", hdr_pops, h1);
        tlp_bus.tlp_ready = 1'b1;
        wait_drain(50);
        check("t2_nbeats", acc_cyc.size(), 3);
        check("t2_hdr_pops", hdr_pops - h0, 1);
        check("t2_pay_pops", pay_pops - p0, 2);

        // Back-to-back single-beat TLPs
        acc_cyc.delete();
        push_tlp(10'd8, 1, 1);
        push_tlp(10'd1, 1, 1);
        wait_drain(50);
        check("t3_nbeats", acc_cyc.size(), 4);
        if (acc_cyc.size() == 4) check("t3_span", acc_cyc[3] - acc_cyc[0], 3);

        // Length mismatches: early rlast, Length=0 max size, late rlast
        push_tlp(10'd24, 2, 2);
        push_tlp(10'd0, 128, 128);
        push_tlp(10'd16, 3, 3);
        wait_drain(400);

        // Payload starvation mid-TLP with a second header waiting
        h0 = hdr_pops; p0 = pay_pops;
        push_tlp(10'd16, 2, 1);
        push_tlp(10'd8, 1, 0);
        n = 0;
        while (pay_pops == p0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_first_beat", pay_pops - p0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_bubble_valid", tlp_bus.tlp_valid, 1'b0);
            check("t5_state_data", dbg_state, 1'b1);
            check("t5_hdr_held", hdr_pops - h0, 1);
        end
        release_payload();
        wait_drain(50);
        check("t5_hdr_pops", hdr_pops - h0, 2);

        // Asynchronous reset right after the header beat loads
        h0 = hdr_pops;
        hdr = {$urandom, $urandom, $urandom, $urandom};
        hdr[9:0] = 10'd16;
        hdr_q.push_back(hdr);
        pay_q.push_back({1'b0, rand_data()});
        refresh();
        n = 0;
        while (hdr_pops == h0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_hdr_loaded", tlp_bus.tlp_sop, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", tlp_bus.tlp_valid, 1'b0);
        check("t6_rst_sop", tlp_bus.tlp_sop, 1'b0);
        check("t6_rst_data", tlp_bus.tlp_data, '0);
        check("t6_rst_state", dbg_state, 1'b0);
        pay_q.delete();
        refresh();
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_cyc.delete();
        push_tlp(10'd8, 1, 1);
        wait_drain(50);
        check("t6_nbeats", acc_cyc.size(), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
